// File: rtl/mem_access_unit.sv
// Load/store initiator between the CPU memory stage and a word-wide data memory.
// Accepts one request at a time. Sub-word stores are done as read-modify-write.
module mem_access_unit #(
  parameter int ADDR_W = 14
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] merge_q, merge_d;
  logic        err_q, err_d;
  logic        is_load_q;

  assign is_load_q = (op_q < OP_SW);

  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] a);
    case (op)
      OP_LW, OP_SW:         return a != 2'b00;
      OP_LH, OP_LHU, OP_SH: return a[0];
      default:              return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] op, input logic [1:0] a,
                                           input logic [31:0] w);
    logic [31:0] shifted;
    logic [15:0] half_v;
    logic [7:0]  byte_v;
    shifted = w >> {a, 3'b000};
    byte_v  = shifted[7:0];
    half_v  = a[1] ? w[31:16] : w[15:0];
    case (op)
      OP_LW:   return w;
      OP_LH:   return {{16{half_v[15]}}, half_v};
      OP_LHU:  return {16'h0000, half_v};
      OP_LB:   return {{24{byte_v[7]}}, byte_v};
      OP_LBU:  return {24'h000000, byte_v};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] merge_word(input logic [2:0] op, input logic [1:0] a,
                                             input logic [31:0] old, input logic [31:0] wd);
    logic [31:0] res;
    res = old;
    case (op)
      OP_SW: res = wd;
      OP_SH: if (a[1]) res[31:16] = wd[15:0];
             else      res[15:0]  = wd[15:0];
      OP_SB: res[{a, 3'b000} +: 8] = wd[7:0];
      default: res = old;
    endcase
    return res;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= 3'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      merge_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      merge_q <= merge_d;
      err_q   <= err_d;
    end
  end

  // Misaligned requests skip memory entirely; sw needs no read, sh/sb read first.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (misaligned(req_op, req_addr[1:0])) state_d = RESP;
          else if (req_op == OP_SW)              state_d = WRITE;
          else                                   state_d = READ;
        end
      end
      READ:    state_d = is_load_q ? RESP : WRITE;
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    merge_d = merge_q;
    err_d   = err_q;
    if (state_q == IDLE && req_valid) begin
      op_d    = req_op;
      addr_d  = req_addr;
      wdata_d = req_wdata;
      rdata_d = 32'h0;
      err_d   = misaligned(req_op, req_addr[1:0]);
    end else if (state_q == READ) begin
      if (is_load_q) rdata_d = load_ext(op_q, addr_q[1:0], mem_rdata);
      else           merge_d = mem_rdata;
    end
  end

  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == RESP);
    resp_err   = 1'b0;
    resp_rdata = 32'h0;
    mem_addr   = 32'h0;
    mem_we     = 1'b0;
    mem_wdata  = 32'h0;
    if (state_q == RESP) begin
      resp_err = err_q;
      if (is_load_q && !err_q) resp_rdata = rdata_q;
    end
    if (state_q == READ || state_q == WRITE)
      mem_addr = {addr_q[31:ADDR_W], addr_q[ADDR_W-1:2], 2'b00};
    if (state_q == WRITE) begin
      // Gated with reset so a write cannot slip through while reset is asserted.
      mem_we    = !reset;
      mem_wdata = merge_word(op_q, addr_q[1:0], merge_q, wdata_q);
    end
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator that sits between the CPU's memory stage and the word-wide data memory. It accepts one load or store request at a time over a valid/ready handshake. It drives the memory's word port, which has a combinational read and a write on the clock edge. It performs sign/zero extension for sub-word loads and a read-modify-write for sub-word stores, then returns a one-cycle response.

## Interface
- ADDR_W, 14: byte-address bits decoded; the memory word index is addr[ADDR_W-1:2]. Upper bits are passed through unchanged.
- clk  in  1  system clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; equals (state == IDLE)
- req_op  in  3  000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu, 101 sw, 110 sh, 111 sb
- req_addr  in  32  byte address
- req_wdata  in  32  store data; sub-word stores use the low bits
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned access; valid only with resp_valid
- mem_addr  out  32  word-aligned address {addr_q[31:2],2'b00} in READ/WRITE, 0 otherwise
- mem_we  out  1  write enable; high only in WRITE
- mem_wdata  out  32  write word in WRITE, 0 otherwise
- mem_rdata  in  32  combinational read of the word at mem_addr

## Operation
- States: IDLE, READ, WRITE, RESP. Outputs are decoded from the state and the latched registers.
- Accept: req_valid && req_ready at a rising edge. On accept, latch op_q, addr_q and wdata_q.
- Misalignment:
  - Word op with addr[1:0] != 0.
  - Half op with addr[0] != 0.
  - A misaligned request goes IDLE -> RESP with resp_err=1 and resp_rdata=0. No memory access is issued.
- Byte lanes are little-endian: byte k = bits [8k+7:8k], k = addr_q[1:0]; half = bits [16h+15:16h], h = addr_q[1].
- Load path: IDLE -> READ -> RESP.
  - At the end of READ, register the extended mem_rdata into rdata_q.
  - lw: full word.
  - lh/lb: sign-extend the selected lane.
  - lhu/lbu: zero-extend the selected lane.
- sw path: IDLE -> WRITE -> RESP. mem_wdata = wdata_q.
- sh/sb path: IDLE -> READ -> WRITE -> RESP.
  - READ captures mem_rdata into merge_q.
  - WRITE drives merge_q with the target lane replaced by wdata_q[15:0] or wdata_q[7:0].
  - All other lanes are preserved.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. resp_rdata = rdata_q for loads and 0 for stores.
- req_valid in any state other than IDLE is ignored; the requester holds it until accepted.
- Invalid op encodings do not exist (all 8 are defined).

## Timing
- Reset (async):
  - State goes to IDLE immediately.
  - Registers clear: rdata_q, merge_q, op_q, addr_q, wdata_q = 0.
  - Outputs: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Reset mid-operation: the transaction is aborted with no response. mem_we drops combinationally with reset. A write in flight at a reset-asserted edge does not occur.
- Latency from the accept edge to the first resp_valid cycle:
  - Misaligned: 1 cycle.
  - Load: 2 cycles.
  - sw: 2 cycles.
  - sh/sb: 3 cycles.
- The memory write occurs at the rising edge that ends the WRITE cycle.
- The earliest next accept is the edge ending RESP, because req_ready is 0 during RESP. Throughput is therefore one request per latency+1 cycles.
- resp_* outputs hold their values only during RESP; outside RESP they are all 0.

## Test plan
- Reset then idle:
  - Stimulus: reset pulse mid-cycle, asynchronous; then hold req_valid=0.
  - Response: req_ready=1 and mem_we=0 immediately; no resp_valid for 10 cycles.
- Word round trip:
  - Stimulus: sw addr 0x0000_0010, data 0xDEAD_BEEF; then lw 0x10.
  - Response: mem_we high one cycle with mem_addr=0x10 and mem_wdata=0xDEADBEEF. The load response follows 2 cycles after accept with resp_rdata=0xDEADBEEF and resp_err=0.
- Sub-word store merge:
  - Stimulus: memory word at 0x20 = 0x1122_3344; sb addr 0x21, data 0xAB; then sh addr 0x22, data 0xCDEF.
  - Response: writes 0x1122_AB44, then 0xCDEF_AB44. Each response arrives 3 cycles after accept.
- Extension:
  - Stimulus: word at 0x30 = 0x80FF_7F01; issue lb 0x33, lbu 0x33, lh 0x32, lhu 0x32, lb 0x30.
  - Response: 0xFFFF_FF80, 0x0000_0080, 0xFFFF_80FF, 0x0000_80FF, 0x0000_0001.
- Misaligned:
  - Stimulus: lw 0x12, sh 0x13, sw 0x01.
  - Response: each returns resp_err=1 and resp_rdata=0 one cycle after accept; mem_we is never asserted and the memory is unchanged.
- Reset during RMW:
  - Stimulus: assert reset during the READ cycle of sb 0x40 (word = 0x5555_5555).
  - Response: no write and no resp_valid; the word is still 0x5555_5555; the unit is back in IDLE with req_ready=1.
